display_axi_lite_regs: RTL and testbench

AXI4-Lite responder (slave) for the display peripheral's S00_AXI port. It holds four 32-bit control registers at byte offsets 0x0, 0x4, 0x8 and 0xC. It accepts single-beat writes and reads from the system interconnect's AXI4-Lite master and exposes the register contents and per-register write strobes to the display core. It is the far end of the S00_AXI link that the interconnect master drives.

---
 rtl/display_axi_lite_regs.sv | 175 +++++++++++++++++
 tb/tb_display_axi_lite_regs.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_axi_lite_regs.sv
// AXI4-Lite register slave for the display peripheral.
// Four 32-bit control registers at offsets 0x0/0x4/0x8/0xC, exposed
// directly to the display core together with per-register write pulses.
// Independent write and read state machines; all handshake outputs are registered.
module display_axi_lite_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
    output logic [3:0]                        reg_wr_pulse_o
);

    localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} r_state_t;

    w_state_t                       w_state_reg;
    logic [1:0]                     wr_sel_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0]  wr_data_reg;
    logic [NUM_BYTES-1:0]           wr_strb_reg;
    logic                           wr_accept_reg;
    logic                           bvalid_reg;
    logic [3:0]                     wr_pulse_reg;

    r_state_t                       r_state_reg;
    logic [1:0]                     rd_sel_reg;
    logic                           arready_reg;
    logic                           rvalid_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0]  rdata_reg;

    logic                           wr_commit;
    logic [C_S_AXI_DATA_WIDTH-1:0]  reg_values [4];

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // The register write happens on the edge that closes W_ACCEPT.
    assign wr_commit = (w_state_reg == W_ACCEPT);

    // Write path: AW and W are taken only together, then one OKAY response.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state_reg   <= W_IDLE;
            wr_sel_reg    <= '0;
            wr_data_reg   <= '0;
            wr_strb_reg   <= '0;
            wr_accept_reg <= 1'b0;
            bvalid_reg    <= 1'b0;
            wr_pulse_reg  <= '0;
        end else begin
            wr_pulse_reg <= '0;
            case (w_state_reg)
                W_IDLE: begin
                    if (s00_axi_awvalid && s00_axi_wvalid) begin
                        wr_sel_reg    <= s00_axi_awaddr[3:2];
                        wr_data_reg   <= s00_axi_wdata;
                        wr_strb_reg   <= s00_axi_wstrb;
                        wr_accept_reg <= 1'b1;
                        w_state_reg   <= W_ACCEPT;
                    end
                end
                W_ACCEPT: begin
                    wr_accept_reg <= 1'b0;
                    bvalid_reg    <= 1'b1;
                    wr_pulse_reg  <= 4'b0001 << wr_sel_reg;
                    w_state_reg   <= W_RESP;
                end
                W_RESP: begin
                    if (s00_axi_bready) begin
                        bvalid_reg  <= 1'b0;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // One storage word per register; byte lanes follow the latched strobes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_reg
        logic [C_S_AXI_DATA_WIDTH-1:0] value_reg;

        // Update only the selected register, lane by lane, at commit.
        always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
            if (!s00_axi_aresetn) begin
                value_reg <= '0;
            end else if (wr_commit && (wr_sel_reg == 2'(gi))) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (wr_strb_reg[b]) begin
                        value_reg[8*b +: 8] <= wr_data_reg[8*b +: 8];
                    end
                end
            end
        end

        assign reg_values[gi] = value_reg;
    end

    // Read path: capture the register on the edge closing R_ACCEPT; a write
    // committing on that same edge is not yet visible, so the old value returns.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state_reg <= R_IDLE;
            rd_sel_reg  <= '0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (s00_axi_arvalid) begin
                        rd_sel_reg  <= s00_axi_araddr[3:2];
                        arready_reg <= 1'b1;
                        r_state_reg <= R_ACCEPT;
                    end
                end
                R_ACCEPT: begin
                    arready_reg <= 1'b0;
                    rdata_reg   <= reg_values[rd_sel_reg];
                    rvalid_reg  <= 1'b1;
                    r_state_reg <= R_DATA;
                end
                R_DATA: begin
                    if (s00_axi_rready) begin
                        rvalid_reg  <= 1'b0;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    assign s00_axi_awready = wr_accept_reg;
    assign s00_axi_wready  = wr_accept_reg;
    assign s00_axi_bvalid  = bvalid_reg;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_reg;
    assign s00_axi_rvalid  = rvalid_reg;
    assign s00_axi_rdata   = rdata_reg;
    assign s00_axi_rresp   = 2'b00;
    assign reg0_o          = reg_values[0];
    assign reg1_o          = reg_values[1];
    assign reg2_o          = reg_values[2];
    assign reg3_o          = reg_values[3];
    assign reg_wr_pulse_o  = wr_pulse_reg;

endmodule

// File: tb/tb_display_axi_lite_regs.sv
// Directed bench for display_axi_lite_regs: write/read of all registers,
// byte strobes, decoupled AW/W arrival, response back-pressure, concurrent
// read and write, same-edge hazard and asynchronous reset mid-transaction.
module tb_display_axi_lite_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, reg0, reg1, reg2, reg3;
    logic [3:0]  pulse;

    int pass_cnt  = 0;
    int total_cnt = 0;

    display_axi_lite_regs dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .reg0_o          (reg0),
        .reg1_o          (reg1),
        .reg2_o          (reg2),
        .reg3_o          (reg3),
        .reg_wr_pulse_o  (pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_sel(input int i);
        case (i)
            0:       return reg0;
            1:       return reg1;
            2:       return reg2;
            default: return reg3;
        endcase
    endfunction

    // Full write transaction; starts and ends on a falling edge.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic ok, output logic [3:0] p, output logic [3:0] p_after,
                            output logic [1:0] resp);
        ok = 1'b0; p = 'x; p_after = 'x; resp = 'x;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready && wready) begin ok = 1'b1; break; end
        end
        if (!ok) begin awvalid = 1'b0; wvalid = 1'b0; return; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        p = pulse;
        for (int i = 0; i < 20 && !bvalid; i++) @(negedge clk);
        ok = bvalid;
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        p_after = pulse;
        bready = 1'b0;
    endtask

    // Full read transaction; starts and ends on a falling edge.
    task automatic do_read(input logic [3:0] a, output logic ok,
                           output logic [31:0] d, output logic [1:0] resp);
        ok = 1'b0; d = 'x; resp = 'x;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        if (!ok) begin arvalid = 1'b0; return; end
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < 20 && !rvalid; i++) @(negedge clk);
        ok = rvalid;
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0)
            $display("FAIL reset_handshake: got %b want 00000", {awready, wready, bvalid, arready, rvalid});
        else pass_cnt++;
        total_cnt++;
        if ({rdata, bresp, rresp} !== 36'h0)
            $display("FAIL reset_rdata_resp: got %h want 0", {rdata, bresp, rresp});
        else pass_cnt++;
        total_cnt++;
        if ({reg0, reg1, reg2, reg3} !== 128'h0)
            $display("FAIL reset_regs: got %h want 0", {reg0, reg1, reg2, reg3});
        else pass_cnt++;
        total_cnt++;
        if (pulse !== 4'b0)
            $display("FAIL reset_pulse: got %b want 0000", pulse);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: released");
    endtask

    task automatic test_write_read_all();
        logic [31:0] vals [4];
        logic ok; logic [3:0] p, pa; logic [1:0] r; logic [31:0] d;
        vals[0] = 32'h0101FFFF; vals[1] = 32'hABCD0001;
        vals[2] = 32'hDEAD0011; vals[3] = 32'hBEEF0011;
        for (int i = 0; i < 4; i++) begin
            do_write(4'(i * 4), vals[i], 4'hF, ok, p, pa, r);
            $display("write addr=%h data=%h pulse=%b bresp=%b", 4'(i * 4), vals[i], p, r);
            total_cnt++;
            if (ok !== 1'b1) $display("FAIL wr%0d_done: got %b want 1", i, ok); else pass_cnt++;
            total_cnt++;
            if (p !== (4'b0001 << i)) $display("FAIL wr%0d_pulse: got %b want %b", i, p, 4'b0001 << i); else pass_cnt++;
            total_cnt++;
            if (pa !== 4'b0) $display("FAIL wr%0d_pulse_clear: got %b want 0000", i, pa); else pass_cnt++;
            total_cnt++;
            if (r !== 2'b00) $display("FAIL wr%0d_bresp: got %b want 00", i, r); else pass_cnt++;
            total_cnt++;
            if (reg_sel(i) !== vals[i]) $display("FAIL wr%0d_regout: got %h want %h", i, reg_sel(i), vals[i]); else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), ok, d, r);
            $display("read  addr=%h data=%h rresp=%b", 4'(i * 4), d, r);
            total_cnt++;
            if (d !== vals[i]) $display("FAIL rd%0d_data: got %h want %h", i, d, vals[i]); else pass_cnt++;
            total_cnt++;
            if ({ok, r} !== 3'b100) $display("FAIL rd%0d_resp: got %b want 100", i, {ok, r}); else pass_cnt++;
        end
    endtask

    task automatic test_strobe();
        logic ok; logic [3:0] p, pa; logic [1:0] r;
        do_write(4'h8, 32'h0, 4'hF, ok, p, pa, r);
        do_write(4'h8, 32'hFFFFFFFF, 4'b0101, ok, p, pa, r);
        $display("write addr=8 data=ffffffff strb=0101 reg2=%h", reg2);
        total_cnt++;
        if (reg2 !== 32'h00FF00FF) $display("FAIL strb_0101: got %h want 00ff00ff", reg2); else pass_cnt++;
        do_write(4'h8, 32'h12345678, 4'b0000, ok, p, pa, r);
        $display("write addr=8 data=12345678 strb=0000 reg2=%h pulse=%b", reg2, p);
        total_cnt++;
        if (reg2 !== 32'h00FF00FF) $display("FAIL strb_zero_data: got %h want 00ff00ff", reg2); else pass_cnt++;
        total_cnt++;
        if ({ok, p, r} !== 7'b1_0100_00) $display("FAIL strb_zero_pulse_resp: got %b want 1010000", {ok, p, r}); else pass_cnt++;
    endtask

    task automatic test_aw_before_w();
        logic seen, ok, dropped, stolen;
        awaddr = 4'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (awready || wready) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL aw_alone_ready: got %b want 0", seen); else pass_cnt++;
        wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL aw_w_accept: got %b want 1", ok); else pass_cnt++;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        $display("write addr=0 data=cafef00d (late W) reg0=%h", reg0);
        total_cnt++;
        if (reg0 !== 32'hCAFEF00D) $display("FAIL late_w_reg0: got %h want cafef00d", reg0); else pass_cnt++;
        // Second write offered while the first response is back-pressured.
        awaddr = 4'h4; wdata = 32'h11112222; awvalid = 1'b1; wvalid = 1'b1;
        dropped = 1'b0; stolen = 1'b0;
        repeat (10) begin
            if (!bvalid) dropped = 1'b1;
            if (awready || wready) stolen = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (dropped !== 1'b0) $display("FAIL bvalid_hold: got dropped=%b want 0", dropped); else pass_cnt++;
        total_cnt++;
        if ({stolen, reg1} !== {1'b0, 32'hABCD0001})
            $display("FAIL no_accept_in_resp: got %b/%h want 0/abcd0001", stolen, reg1);
        else pass_cnt++;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        total_cnt++;
        if ({bvalid, awready} !== 2'b00) $display("FAIL b_handshake: got %b want 00", {bvalid, awready}); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (awready !== 1'b1) $display("FAIL second_accept_timing: got %b want 1", awready); else pass_cnt++;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        $display("write addr=4 data=11112222 (after B) reg1=%h pulse=%b", reg1, pulse);
        total_cnt++;
        if ({pulse, reg1} !== {4'b0010, 32'h11112222})
            $display("FAIL second_write: got %b/%h want 0010/11112222", pulse, reg1);
        else pass_cnt++;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic test_rready_hold();
        logic ok, stable; logic [3:0] p, pa; logic [1:0] r; logic [31:0] d;
        araddr = 4'h0; arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        arvalid = 1'b0;
        total_cnt++;
        if ({ok, rvalid, rdata} !== {2'b11, 32'hCAFEF00D})
            $display("FAIL hold_read_first: got %b%b/%h want 11/cafef00d", ok, rvalid, rdata);
        else pass_cnt++;
        do_write(4'h4, 32'h12345678, 4'hF, ok, p, pa, r);
        $display("write addr=4 data=12345678 during held read pulse=%b reg1=%h", p, reg1);
        total_cnt++;
        if ({ok, p, reg1} !== {1'b1, 4'b0010, 32'h12345678})
            $display("FAIL concurrent_write: got %b/%b/%h want 1/0010/12345678", ok, p, reg1);
        else pass_cnt++;
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (!rvalid || rdata !== 32'hCAFEF00D) stable = 1'b0;
        end
        total_cnt++;
        if (stable !== 1'b1) $display("FAIL rdata_stable: got %b want 1 (rdata=%h)", stable, rdata); else pass_cnt++;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        total_cnt++;
        if (rvalid !== 1'b0) $display("FAIL r_handshake: got %b want 0", rvalid); else pass_cnt++;
        do_read(4'h4, ok, d, r);
        $display("read  addr=4 data=%h", d);
        total_cnt++;
        if (d !== 32'h12345678) $display("FAIL readback_4: got %h want 12345678", d); else pass_cnt++;
    endtask

    task automatic test_same_edge();
        awaddr = 4'hC; wdata = 32'h0; wstrb = 4'hF; araddr = 4'hC;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({awready, wready, arready} !== 3'b111)
            $display("FAIL same_edge_accept: got %b want 111", {awready, wready, arready});
        else pass_cnt++;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        $display("same-edge addr=c read=%h reg3=%h pulse=%b", rdata, reg3, pulse);
        total_cnt++;
        if ({rvalid, rdata} !== {1'b1, 32'hBEEF0011})
            $display("FAIL same_edge_old_value: got %b/%h want 1/beef0011", rvalid, rdata);
        else pass_cnt++;
        total_cnt++;
        if ({pulse, reg3} !== {4'b1000, 32'h0})
            $display("FAIL same_edge_write: got %b/%h want 1000/00000000", pulse, reg3);
        else pass_cnt++;
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        total_cnt++;
        if ({bvalid, rvalid} !== 2'b00) $display("FAIL same_edge_close: got %b want 00", {bvalid, rvalid}); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic ok; logic [3:0] p, pa; logic [1:0] r; logic [31:0] d;
        araddr = 4'h4; arvalid = 1'b1;
        for (int i = 0; i < 10 && !arready; i++) @(negedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        awaddr = 4'h0; wdata = 32'h55AA55AA; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({rvalid, awready} !== 2'b11) $display("FAIL pre_reset_state: got %b want 11", {rvalid, awready}); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-transaction: handshakes=%b reg0=%h", {awready, wready, bvalid, arready, rvalid}, reg0);
        total_cnt++;
        if ({awready, wready, bvalid, arready, rvalid, rdata} !== 37'h0)
            $display("FAIL async_reset_outputs: got %h want 0", {awready, wready, bvalid, arready, rvalid, rdata});
        else pass_cnt++;
        total_cnt++;
        if ({reg0, reg1, reg2, reg3} !== 128'h0)
            $display("FAIL async_reset_regs: got %h want 0", {reg0, reg1, reg2, reg3});
        else pass_cnt++;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_write(4'h0, 32'h0F0F0F0F, 4'hF, ok, p, pa, r);
        $display("write addr=0 data=0f0f0f0f after reset reg0=%h", reg0);
        total_cnt++;
        if ({ok, p, reg0} !== {1'b1, 4'b0001, 32'h0F0F0F0F})
            $display("FAIL post_reset_write: got %b/%b/%h want 1/0001/0f0f0f0f", ok, p, reg0);
        else pass_cnt++;
        do_read(4'h0, ok, d, r);
        $display("read  addr=0 data=%h after reset", d);
        total_cnt++;
        if ({ok, d} !== {1'b1, 32'h0F0F0F0F}) $display("FAIL post_reset_read: got %b/%h want 1/0f0f0f0f", ok, d); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read_all();
        test_strobe();
        test_aw_before_w();
        test_rready_hold();
        test_same_edge();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
